// File: rtl/register_file_sb.sv
// Multi-port register file with write-to-read forwarding and an
// integrated busy-bit scoreboard for decode-stage stall detection.
module register_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int ZERO_REG   = 1,
  localparam int IDX_W     = $clog2(NUM_REGS),
  localparam int CNT_W     = $clog2(NUM_REGS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*IDX_W-1:0]      rd_idx,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*IDX_W-1:0]      wr_idx,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic                         iss_en,
  input  logic [IDX_W-1:0]             iss_idx,
  output logic [CNT_W-1:0]             busy_cnt
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [NUM_WR-1:0]     wr_ok;

  always_comb begin
    wr_ok = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      wr_ok[w] = wr_en[w] &&
                 !((ZERO_REG != 0) &&
                   (wr_idx[w*IDX_W +: IDX_W] == '0));
    end
  end

  // Issue is applied after write-back so the newer producer wins.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w]) busy_d[wr_idx[w*IDX_W +: IDX_W]] = 1'b0;
    end
    if (iss_en) busy_d[iss_idx] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d = cnt_d + CNT_W'(busy_d[r]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Later ports overwrite earlier ones, giving higher index priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_ok[w]) begin
          regs_q[wr_idx[w*IDX_W +: IDX_W]] <=
            wr_data[w*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] data;
    logic                  hit;

    assign idx = rd_idx[p*IDX_W +: IDX_W];

    always_comb begin
      data = regs_q[idx];
      hit  = 1'b0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_idx[w*IDX_W +: IDX_W] == idx)) begin
          data = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
          hit  = 1'b1;
        end
      end
      if ((ZERO_REG != 0) && (idx == '0)) data = '0;
      if (rst) data = '0;
    end

    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = data;
    assign rd_busy[p] = busy_q[idx] && !hit && !rst;
  end

  assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench for register_file_sb: stimulus queues expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_register_file_sb;

  localparam int DW    = 32;
  localparam int NR    = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int IW    = 5;
  localparam int CW    = 6;

  logic              clk;
  logic              rst;
  logic [NRD*IW-1:0] rd_idx;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic [NWR-1:0]    wr_en;
  logic [NWR*IW-1:0] wr_idx;
  logic [NWR*DW-1:0] wr_data;
  logic              iss_en;
  logic [IW-1:0]     iss_idx;
  logic [CW-1:0]     busy_cnt;

  register_file_sb #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD(NRD),
    .NUM_WR(NWR), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_idx(rd_idx), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .iss_en(iss_en), .iss_idx(iss_idx), .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    kind;
    logic [1:0]    port;
    logic [31:0]   exp;
    logic [63:0]   name;
  } chk_t;

  chk_t q[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic expect_v(input logic [1:0] kind, input logic [1:0] port,
                          input logic [31:0] exp, input logic [63:0] name);
    chk_t e;
    e.kind = kind;
    e.port = port;
    e.exp  = exp;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic exp_rd(input int p, input logic [31:0] v,
                        input logic [63:0] nm);
    expect_v(2'd0, 2'(p), v, nm);
  endtask

  task automatic exp_busy(input int p, input logic b,
                          input logic [63:0] nm);
    expect_v(2'd1, 2'(p), {31'd0, b}, nm);
  endtask

  task automatic exp_cnt(input int c, input logic [63:0] nm);
    expect_v(2'd2, 2'd0, 32'(c), nm);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.kind)
        2'd0:    act = rd_data[int'(e.port)*DW +: DW];
        2'd1:    act = {31'd0, rd_busy[e.port]};
        default: act = {26'd0, busy_cnt};
      endcase
      n_total++;
      if (act === e.exp) n_pass++;
      else $display("FAIL %0s: got %h expected %h", e.name, act, e.exp);
    end
  end

  task automatic step(input logic [1:0] we,
                      input int wi0, input logic [31:0] wd0,
                      input int wi1, input logic [31:0] wd1,
                      input logic ie, input int ii,
                      input int r0, input int r1);
    @(posedge clk);
    #1;
    wr_en   = we;
    wr_idx  = {IW'(wi1), IW'(wi0)};
    wr_data = {wd1, wd0};
    iss_en  = ie;
    iss_idx = IW'(ii);
    rd_idx  = {IW'(r1), IW'(r0)};
  endtask

  task automatic idle(input int r0, input int r1);
    step(2'b00, 0, 0, 0, 0, 1'b0, 0, r0, r1);
  endtask

  initial begin
    rst = 1'b1;
    wr_en = '0; wr_idx = '0; wr_data = '0;
    iss_en = 1'b0; iss_idx = '0;
    rd_idx = {IW'(6), IW'(5)};
    exp_rd(0, 32'h0, "rst_rd");
    exp_busy(0, 1'b0, "rst_bsy");
    exp_cnt(0, "rst_cnt");
    @(negedge clk);
    #1 rst = 1'b0;

    // 1: write x5, forwarded then stored
    step(2'b01, 5, 32'hAAAAAAAA, 0, 0, 1'b0, 0, 5, 5);
    exp_rd(0, 32'hAAAAAAAA, "t1_fwd0");
    exp_rd(1, 32'hAAAAAAAA, "t1_fwd1");
    idle(5, 6);
    exp_rd(0, 32'hAAAAAAAA, "t1_st5");
    exp_rd(1, 32'h0, "t1_x6");

    // 2: same-index dual write, port 1 wins
    step(2'b11, 10, 32'h11111111, 10, 32'hDEADBEEF, 1'b0, 0, 10, 10);
    exp_rd(0, 32'hDEADBEEF, "t2_fwd");
    idle(10, 5);
    exp_rd(0, 32'hDEADBEEF, "t2_st");
    exp_rd(1, 32'hAAAAAAAA, "t2_x5");

    // 3: issue x7, then write-back clears
    step(2'b00, 0, 0, 0, 0, 1'b1, 7, 7, 7);
    exp_busy(0, 1'b0, "t3_iss0");
    exp_cnt(0, "t3_cnt0");
    idle(7, 7);
    exp_busy(0, 1'b1, "t3_bsy");
    exp_cnt(1, "t3_cnt1");
    step(2'b01, 7, 32'h1234, 0, 0, 1'b0, 0, 7, 7);
    exp_busy(0, 1'b0, "t3_fwdb");
    exp_rd(0, 32'h1234, "t3_fwdd");
    exp_cnt(1, "t3_cnt1b");
    idle(7, 7);
    exp_cnt(0, "t3_cnt2");
    exp_busy(1, 1'b0, "t3_bsy2");
    exp_rd(1, 32'h1234, "t3_st");

    // 4: issue beats write-back on x3
    step(2'b00, 0, 0, 0, 0, 1'b1, 3, 3, 3);
    step(2'b10, 0, 0, 3, 32'h55, 1'b1, 3, 3, 3);
    exp_busy(0, 1'b0, "t4_fwdb");
    exp_rd(0, 32'h55, "t4_fwdd");
    exp_cnt(1, "t4_cnt");
    idle(3, 3);
    exp_busy(0, 1'b1, "t4_bsy");
    exp_rd(1, 32'h55, "t4_st");
    exp_cnt(1, "t4_cnt2");

    // 5: x0 ignores write and issue
    step(2'b01, 0, 32'hFFFFFFFF, 0, 0, 1'b1, 0, 0, 0);
    exp_rd(0, 32'h0, "t5_fwd");
    exp_busy(1, 1'b0, "t5_bsy");
    exp_cnt(1, "t5_cnt");
    step(2'b01, 3, 32'h66, 0, 0, 1'b0, 0, 0, 3);
    exp_rd(0, 32'h0, "t5_st");
    exp_cnt(1, "t5_cnt2");
    exp_rd(1, 32'h66, "t5_x3f");

    // distinct indexes on both ports both land
    step(2'b11, 13, 32'hC0DE0013, 12, 32'hC0DE0012, 1'b0, 0, 12, 13);
    exp_cnt(0, "cnt_clr");
    idle(12, 13);
    exp_rd(0, 32'hC0DE0012, "x12");
    exp_rd(1, 32'hC0DE0013, "x13");

    // 6: fill three busy bits, then reset between edges
    step(2'b00, 0, 0, 0, 0, 1'b1, 1, 1, 2);
    step(2'b00, 0, 0, 0, 0, 1'b1, 2, 1, 2);
    exp_cnt(1, "t6_cnt1");
    step(2'b00, 0, 0, 0, 0, 1'b1, 3, 1, 2);
    exp_cnt(2, "t6_cnt2");
    idle(1, 2);
    exp_cnt(3, "t6_cnt3");
    exp_busy(0, 1'b1, "t6_b1");
    exp_busy(1, 1'b1, "t6_b2");
    step(2'b01, 1, 32'h77, 0, 0, 1'b1, 4, 1, 13);
    #2 rst = 1'b1;
    exp_rd(0, 32'h0, "t6_rrd");
    exp_rd(1, 32'h0, "t6_rx13");
    exp_busy(0, 1'b0, "t6_rbsy");
    exp_cnt(0, "t6_rcnt");
    idle(1, 5);
    rst = 1'b0;
    exp_rd(0, 32'h0, "t6_x1");
    exp_rd(1, 32'h0, "t6_x5");
    exp_busy(0, 1'b0, "t6_bsy");
    exp_cnt(0, "t6_cnt");

    @(posedge clk);
    @(posedge clk);
    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
